// File: rtl/insn_encoder.sv
// insn_encoder: z-subset symbolic instruction -> serial x86-style byte stream.
// Optional counters: define INSN_ENCODER_COUNT_EN for insn_cnt/byte_cnt.  Rev 1.0
`default_nettype none

module insn_encoder #(
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cls,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rs,
  input  logic [IMM_W-1:0] in_imm,
  input  logic             in_use_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             err
`ifdef INSN_ENCODER_COUNT_EN
  ,
  output logic [31:0]      insn_cnt,
  output logic [31:0]      byte_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [2:0]  len;
  logic [7:0]  enc [4];
  logic        err_q;

  logic [7:0]  enc_nxt [4];
  logic [2:0]  len_nxt;
  logic        illegal;
  logic [2:0]  ext;
  logic [7:0]  opc;
  logic [7:0]  imm_lo;
  logic [7:0]  imm_hi;
  logic        accept;
  logic        xfer;

  assign imm_lo = in_imm[7:0];
  assign imm_hi = in_imm[15:8];

  // Build the full byte image of the presented instruction in one cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) enc_nxt[i] = 8'h00;
    len_nxt = 3'd0;
    illegal = 1'b0;
    ext     = 3'd0;
    opc     = 8'h00;
    case (in_cls)
      4'd0: begin
        enc_nxt[0] = 8'h8B;
        enc_nxt[1] = {2'b01, in_rd, in_rs};
        enc_nxt[2] = imm_lo;
        len_nxt    = 3'd3;
      end
      4'd1: begin
        enc_nxt[0] = 8'h89;
        enc_nxt[1] = {2'b01, in_rs, in_rd};
        enc_nxt[2] = imm_lo;
        len_nxt    = 3'd3;
      end
      4'd2: begin
        enc_nxt[0] = 8'h66;
        enc_nxt[1] = {5'b10111, in_rd};
        enc_nxt[2] = imm_lo;
        enc_nxt[3] = imm_hi;
        len_nxt    = 3'd4;
      end
      4'd3: begin
        enc_nxt[0] = 8'h89;
        enc_nxt[1] = {2'b11, in_rs, in_rd};
        len_nxt    = 3'd2;
      end
      4'd4: begin
        case (in_op)
          4'd0:    begin opc = 8'h01; ext = 3'd0; end
          4'd1:    begin opc = 8'h29; ext = 3'd5; end
          4'd2:    begin opc = 8'h39; ext = 3'd7; end
          4'd3:    begin opc = 8'h21; ext = 3'd4; end
          4'd4:    begin opc = 8'h09; ext = 3'd1; end
          4'd5:    begin opc = 8'h31; ext = 3'd6; end
          default: illegal = 1'b1;
        endcase
        if (in_use_im) begin
          enc_nxt[0] = 8'h83;
          enc_nxt[1] = {2'b11, ext, in_rd};
          enc_nxt[2] = imm_lo;
          len_nxt    = 3'd3;
        end else begin
          enc_nxt[0] = opc;
          enc_nxt[1] = {2'b11, in_rs, in_rd};
          len_nxt    = 3'd2;
        end
      end
      4'd5: begin
        case (in_op)
          4'd6:    ext = 3'd3;
          4'd7:    ext = 3'd2;
          default: illegal = 1'b1;
        endcase
        enc_nxt[0] = 8'hF7;
        enc_nxt[1] = {2'b11, ext, in_rd};
        len_nxt    = 3'd2;
      end
      4'd6: begin
        case (in_op)
          4'd8:    ext = 3'd4;
          4'd9:    ext = 3'd5;
          4'd10:   ext = 3'd7;
          default: illegal = 1'b1;
        endcase
        enc_nxt[0] = 8'hC1;
        enc_nxt[1] = {2'b11, ext, in_rd};
        enc_nxt[2] = imm_lo;
        len_nxt    = 3'd3;
      end
      4'd7: begin
        enc_nxt[0] = 8'hEB;
        enc_nxt[1] = imm_lo;
        len_nxt    = 3'd2;
      end
      4'd8: begin
        enc_nxt[0] = 8'hF4;
        len_nxt    = 3'd1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_byte  = out_valid ? enc[idx] : 8'h00;
  assign out_last  = out_valid && ({1'b0, idx} == (len - 3'd1));
  assign err       = err_q;
  assign accept    = in_ready && in_valid;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && !illegal) state_nxt = EMIT;
      EMIT:    if (xfer && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 2'd0;
      len   <= 3'd0;
      err_q <= 1'b0;
      for (int i = 0; i < 4; i++) enc[i] <= 8'h00;
    end else begin
      err_q <= accept && illegal;
      if (accept && !illegal) begin
        idx <= 2'd0;
        len <= len_nxt;
        for (int i = 0; i < 4; i++) enc[i] <= enc_nxt[i];
      end else if (xfer && !out_last) begin
        idx <= idx + 2'd1;
      end
    end
  end

`ifdef INSN_ENCODER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      insn_cnt <= 32'd0;
      byte_cnt <= 32'd0;
    end else if (xfer) begin
      byte_cnt <= byte_cnt + 32'd1;
      if (out_last) insn_cnt <= insn_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: table vectors, hand sequences and randomized instructions
// checked against a spec-level encoding model.
`default_nettype none

module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cls;
  logic [3:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [15:0] in_imm;
  logic        in_use_im;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        err;
`ifdef INSN_ENCODER_COUNT_EN
  logic [31:0] insn_cnt;
  logic [31:0] byte_cnt;
`endif

  int tests  = 0;
  int failed = 0;
  int exp_insn  = 0;
  int exp_bytes = 0;

  always #5 clk = ~clk;

  insn_encoder #(.IMM_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cls    (in_cls),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_imm    (in_imm),
    .in_use_im (in_use_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .err       (err)
`ifdef INSN_ENCODER_COUNT_EN
    ,
    .insn_cnt  (insn_cnt),
    .byte_cnt  (byte_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  cls;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic        use_im;
    logic [15:0] pat;
    int          len;
    logic [31:0] b;
  } vec_t;

  localparam logic [7:0] REG_OPC [6] = '{8'h01, 8'h29, 8'h39, 8'h21, 8'h09, 8'h31};
  localparam logic [2:0] IMM_EXT [6] = '{3'd0, 3'd5, 3'd7, 3'd4, 3'd1, 3'd6};
  localparam logic [2:0] SH_EXT  [3] = '{3'd4, 3'd5, 3'd7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoding; len == 0 marks an illegal instruction.
  function automatic void model(input logic [3:0] cls, input logic [3:0] op,
                                input logic [2:0] rd, input logic [2:0] rs,
                                input logic [15:0] imm, input logic use_im,
                                output int len, output logic [31:0] b);
    len = 0;
    b   = 32'h0;
    case (cls)
      4'd0: begin len = 3; b = {8'h8B, 2'b01, rd, rs, imm[7:0], 8'h00}; end
      4'd1: begin len = 3; b = {8'h89, 2'b01, rs, rd, imm[7:0], 8'h00}; end
      4'd2: begin len = 4; b = {8'h66, 8'hB8 + {5'd0, rd}, imm[7:0], imm[15:8]}; end
      4'd3: begin len = 2; b = {8'h89, 2'b11, rs, rd, 16'h0}; end
      4'd4: if (op <= 4'd5) begin
        if (use_im) begin len = 3; b = {8'h83, 2'b11, IMM_EXT[op], rd, imm[7:0], 8'h00}; end
        else        begin len = 2; b = {REG_OPC[op], 2'b11, rs, rd, 16'h0}; end
      end
      4'd5: if (op == 4'd6 || op == 4'd7) begin
        len = 2;
        b   = {8'hF7, 2'b11, (op == 4'd6) ? 3'd3 : 3'd2, rd, 16'h0};
      end
      4'd6: if (op >= 4'd8 && op <= 4'd10) begin
        len = 3;
        b   = {8'hC1, 2'b11, SH_EXT[op - 4'd8], rd, imm[7:0], 8'h00};
      end
      4'd7: begin len = 2; b = {8'hEB, imm[7:0], 16'h0}; end
      4'd8: begin len = 1; b = {8'hF4, 24'h0}; end
      default: len = 0;
    endcase
  endfunction

  // Present one instruction, then drain its bytes under the out_ready pattern.
  task automatic run(input vec_t v);
    int  k;
    int  cyc;
    bit  done;
    logic rdy;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_cls    = v.cls;
    in_op     = v.op;
    in_rd     = v.rd;
    in_rs     = v.rs;
    in_imm    = v.imm;
    in_use_im = v.use_im;
    @(negedge clk);
    in_valid  = 1'b0;
    in_cls    = 4'($urandom);
    in_op     = 4'($urandom);
    in_imm    = 16'($urandom);
    if (v.len == 0) begin
      check("err_pulse", err, 1);
      check("err_out_valid", out_valid, 0);
      check("err_in_ready", in_ready, 1);
      @(negedge clk);
      check("err_clear", err, 0);
      check("err_out_valid2", out_valid, 0);
    end else begin
      k = 0; cyc = 0; done = 0;
      while (!done && cyc < 40) begin
        check("out_valid", out_valid, 1);
        check("out_byte", out_byte, v.b[31 - 8*k -: 8]);
        check("out_last", out_last, (k == v.len - 1));
        check("in_ready_busy", in_ready, 0);
        rdy = (cyc < 16) ? v.pat[cyc] : 1'b1;
        out_ready = rdy;
        @(negedge clk);
        out_ready = 1'b0;
        if (rdy) begin
          exp_bytes++;
          if (k == v.len - 1) begin done = 1; exp_insn++; end
          else k++;
        end
        cyc++;
      end
      if (!done) check("emit_timeout", 0, 1);
      check("done_out_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
    end
  endtask

  vec_t tbl [16];
  vec_t rv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_cls = '0; in_op = '0; in_rd = '0; in_rs = '0; in_imm = '0; in_use_im = 1'b0;

    tbl[0]  = '{4'd4, 4'd0,  3'd1, 3'd2, 16'h0000, 1'b0, 16'hFFFF, 2, 32'h01D1_0000};
    tbl[1]  = '{4'd0, 4'd5,  3'd0, 3'd3, 16'h0010, 1'b1, 16'hFFFF, 3, 32'h8B43_1000};
    tbl[2]  = '{4'd2, 4'd0,  3'd2, 3'd0, 16'h1234, 1'b0, 16'hFFFF, 4, 32'h66BA_3412};
    tbl[3]  = '{4'd6, 4'd10, 3'd1, 3'd0, 16'h0003, 1'b0, 16'hFFF9, 3, 32'hC1F9_0300};
    tbl[4]  = '{4'd9, 4'd0,  3'd0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 0, 32'h0};
    tbl[5]  = '{4'd4, 4'd8,  3'd0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 0, 32'h0};
    tbl[6]  = '{4'd1, 4'd0,  3'd5, 3'd2, 16'hFF80, 1'b0, 16'hFFFF, 3, 32'h8955_8000};
    tbl[7]  = '{4'd3, 4'd0,  3'd7, 3'd0, 16'h0000, 1'b1, 16'hFFFF, 2, 32'h89C7_0000};
    tbl[8]  = '{4'd4, 4'd2,  3'd3, 3'd0, 16'h007F, 1'b1, 16'hFFFF, 3, 32'h83FB_7F00};
    tbl[9]  = '{4'd5, 4'd7,  3'd4, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 2, 32'hF7D4_0000};
    tbl[10] = '{4'd7, 4'd0,  3'd0, 3'd0, 16'h00FE, 1'b0, 16'hFFFF, 2, 32'hEBFE_0000};
    tbl[11] = '{4'd8, 4'd0,  3'd0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 1, 32'hF400_0000};
    tbl[12] = '{4'd5, 4'd0,  3'd0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 0, 32'h0};
    tbl[13] = '{4'd6, 4'd6,  3'd0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 0, 32'h0};
    tbl[14] = '{4'd4, 4'd6,  3'd0, 3'd0, 16'h0000, 1'b1, 16'hFFFF, 0, 32'h0};
    tbl[15] = '{4'd15, 4'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 16'hFFFF, 0, 32'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);

    for (int i = 0; i < 16; i++) run(tbl[i]);

    for (int i = 0; i < 200; i++) begin
      rv.cls    = 4'($urandom_range(0, 9));
      rv.op     = 4'($urandom_range(0, 11));
      rv.rd     = 3'($urandom);
      rv.rs     = 3'($urandom);
      rv.imm    = 16'($urandom);
      rv.use_im = 1'($urandom);
      rv.pat    = 16'($urandom);
      model(rv.cls, rv.op, rv.rd, rv.rs, rv.imm, rv.use_im, rv.len, rv.b);
      run(rv);
    end

`ifdef INSN_ENCODER_COUNT_EN
    check("insn_cnt", insn_cnt, exp_insn);
    check("byte_cnt", byte_cnt, exp_bytes);
`endif

    // Reset in the middle of a LIL after two bytes have gone out.
    @(negedge clk);
    in_valid = 1'b1; in_cls = 4'd2; in_rd = 3'd2; in_imm = 16'h1234; in_op = 4'd0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_byte2", out_byte, 8'h34);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_insn = 0; exp_bytes = 0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_byte", out_byte, 0);
    check("mid_rst_out_last", out_last, 0);
`ifdef INSN_ENCODER_COUNT_EN
    check("mid_rst_insn_cnt", insn_cnt, 0);
    check("mid_rst_byte_cnt", byte_cnt, 0);
`endif
    run(tbl[11]);
`ifdef INSN_ENCODER_COUNT_EN
    check("final_insn_cnt", insn_cnt, exp_insn);
    check("final_byte_cnt", byte_cnt, exp_bytes);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
